// File: rtl/pwm_pkg.sv
// Shared definitions for the candle-flicker PWM path. The generator and the
// capture block both import this package.
package pwm_pkg;

    localparam int PWM_WIDTH = 8;
    localparam int PWM_FRAME = 256;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ALIGN   = 2'd1,
        CAP_MEASURE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/bit_sync.sv
// N-flop synchroniser for a single asynchronous input. Async active-low reset
// clears every stage, so the output reads 0 until N clocks after release.
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/pwm_capture.sv
// Duty-cycle decoder: counts high samples of pwm_in over 256-tick frames and
// reports the 8-bit generator value that would produce that high time.
//
// state       | meaning
// CAP_IDLE    | after reset, waiting for the first enable tick
// CAP_ALIGN   | hunting for a rising edge, gives up after 256 ticks
// CAP_MEASURE | accumulating high samples, publishing every 256 ticks
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 restart,
    input  logic                 pwm_in,
    output logic [PWM_WIDTH-1:0] value,
    output logic                 valid,
    output logic                 locked
);

    localparam logic [PWM_WIDTH-1:0] LAST_TICK = PWM_WIDTH'(PWM_FRAME - 1);

    cap_state_t           r_state;
    cap_state_t           w_state_nxt;
    logic                 r_prev_s;
    logic [PWM_WIDTH-1:0] r_timeout;
    logic [PWM_WIDTH-1:0] r_tick;
    logic [PWM_WIDTH:0]   r_acc;
    logic [PWM_WIDTH-1:0] r_value;
    logic                 r_valid;
    logic                 r_locked;

    logic                 w_pwm_s;
    logic                 w_rise;
    logic [PWM_WIDTH:0]   w_sum;
    logic [PWM_WIDTH-1:0] w_timeout_nxt;
    logic [PWM_WIDTH-1:0] w_tick_nxt;
    logic [PWM_WIDTH:0]   w_acc_nxt;
    logic                 w_locked_nxt;
    logic                 w_publish;

    bit_sync #(.N(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (pwm_in),
        .o_q     (w_pwm_s)
    );

    assign w_rise = !r_prev_s && w_pwm_s;
    assign w_sum  = r_acc + {{PWM_WIDTH{1'b0}}, w_pwm_s};

    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_nxt = r_timeout;
        w_tick_nxt    = r_tick;
        w_acc_nxt     = r_acc;
        w_locked_nxt  = r_locked;
        w_publish     = 1'b0;

        if (restart) begin
            w_state_nxt   = CAP_ALIGN;
            w_timeout_nxt = '0;
            w_tick_nxt    = '0;
            w_acc_nxt     = '0;
            w_locked_nxt  = 1'b0;
        end else if (enable) begin
            case (r_state)
                CAP_IDLE: begin
                    w_state_nxt = CAP_ALIGN;
                end
                CAP_ALIGN: begin
                    // Both the lock tick and the timeout tick are frame tick 0.
                    if (w_rise || (r_timeout == LAST_TICK)) begin
                        w_state_nxt   = CAP_MEASURE;
                        w_locked_nxt  = w_rise;
                        w_timeout_nxt = '0;
                        w_tick_nxt    = PWM_WIDTH'(1);
                        w_acc_nxt     = {{PWM_WIDTH{1'b0}}, w_pwm_s};
                    end else begin
                        w_timeout_nxt = r_timeout + PWM_WIDTH'(1);
                    end
                end
                CAP_MEASURE: begin
                    w_tick_nxt = r_tick + PWM_WIDTH'(1);
                    if (r_tick == LAST_TICK) begin
                        w_publish = 1'b1;
                        w_acc_nxt = '0;
                    end else begin
                        w_acc_nxt = w_sum;
                    end
                end
                default: begin
                    w_state_nxt = CAP_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CAP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_s  <= 1'b0;
            r_timeout <= '0;
            r_tick    <= '0;
            r_acc     <= '0;
            r_value   <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            if (enable) begin
                r_prev_s <= w_pwm_s;
            end
            r_timeout <= w_timeout_nxt;
            r_tick    <= w_tick_nxt;
            r_acc     <= w_acc_nxt;
            r_locked  <= w_locked_nxt;
            r_valid   <= w_publish;
            // A full frame of high samples counts 256, which saturates to 255.
            if (w_publish) begin
                r_value <= w_sum[PWM_WIDTH] ? {PWM_WIDTH{1'b1}} : w_sum[PWM_WIDTH-1:0];
            end
        end
    end

    assign value  = r_value;
    assign valid  = r_valid;
    assign locked = r_locked;

endmodule
